// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter for the 40-bit serial link: start bit, WIDTH data
// bits LSB-first, then GAP low cycles. A one-word holding register queues the next frame.
module serial_transmitter #(
  parameter int WIDTH = 40,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             so,
  output logic             busy,
  output logic             tx_done
);

  typedef enum logic [2:0] {S_GUARD, S_IDLE, S_START, S_DATA, S_GAP} state_t;

  localparam int CW = $clog2(WIDTH + GAP + 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(WIDTH + GAP - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
  logic             take;

  assign data_ready = rst_n && !full_q;
  assign busy       = rst_n && (state_q != S_IDLE);
  assign so         = so_q;
  assign tx_done    = done_q;
  assign take       = data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GUARD;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  // so is registered: each branch computes the line level for the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    so_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (full_q) begin
          state_d = S_START;
          so_d    = 1'b1;
        end
      end
      S_START: begin
        state_d = S_DATA;
        so_d    = hold_q[0];
        shift_d = hold_q >> 1;
        full_d  = 1'b0;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          so_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (full_q) begin
            state_d = S_START;
            so_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_GUARD;
    endcase
    // take implies the holding register is empty, so this never clobbers a held word
    if (take) begin
      hold_d = data;
      full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboarded bench for serial_transmitter: a frame-level model predicts the start
// edge and contents of every frame; a negedge monitor decodes the line and compares.
module tb_serial_transmitter;
  localparam int W = 40;
  localparam int G = 2;
  localparam int PERIOD = 1 + W + G;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, so, busy, tx_done;

  serial_transmitter #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .so(so), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    int           st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rbase = 0;
  int   prev_st = -1000;
  int   checks = 0;
  int   errors = 0;
  bit   in_frame = 1'b0;
  int   fst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [W-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Frame model: a word leaves no earlier than one edge after its transfer, the
  // end of the post-reset guard, or one full frame period after its predecessor.
  task automatic send(input logic [W-1:0] w, input bit bp);
    int n = 0;
    int e0, st;
    data = w;
    data_valid = 1'b1;
    while (!data_ready && n < 500) begin
      @(negedge clk);
      n++;
      if (!data_ready && bp) data = rnd40();
    end
    if (!data_ready) begin
      fail("send_timeout");
      data_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    st = e0 + 1;
    if (rbase + PERIOD > st) st = rbase + PERIOD;
    if (prev_st + PERIOD > st) st = prev_st + PERIOD;
    prev_st = st;
    q.push_back('{w: data, st: st});
    @(negedge clk);
    data_valid = 1'b0;
    data = rnd40();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    rbase = cyc;
    #1;
  endtask

  task automatic drain_and_idle(input string nm);
    int n = 0;
    while ((q.size() != 0 || in_frame) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || in_frame) fail({nm, "_drain_timeout"});
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_ready"}, data_ready, 1);
    chk({nm, "_idle_so"}, so, 0);
  endtask

  // Monitor: decodes the serial line frame by frame against the scoreboard.
  initial begin
    exp_t e;
    logic [W-1:0] fw = '0;
    int off;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        chk("rst_so", so, 0);
      end else if (!in_frame) begin
        chk("tx_done_quiet", tx_done, 0);
        if ((cyc - rbase) < PERIOD - 1) begin
          chk("guard_busy", busy, 1);
          chk("guard_so", so, 0);
        end else if (so) begin
          if (q.size() == 0) begin
            fail("unexpected_start");
          end else begin
            e = q.pop_front();
            chk("start_cycle", 64'(cyc), 64'(e.st));
            chk("start_busy", busy, 1);
            fw = e.w;
            fst = cyc;
            in_frame = 1'b1;
          end
        end else begin
          chk("idle_busy", busy, 0);
        end
      end else begin
        off = cyc - fst;
        chk("frame_busy", busy, 1);
        if (off <= W) begin
          chk("data_bit", so, fw[off-1]);
          chk("tx_done_data", tx_done, 0);
        end else if (off == W + 1) begin
          chk("gap1_so", so, 0);
          chk("tx_done_pulse", tx_done, 1);
        end else begin
          chk("gap_so", so, 0);
          chk("tx_done_gap", tx_done, 0);
          if (off >= PERIOD - 1) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values, with a word already offered
    data = 40'hA5_5A0F_F0C3;
    data_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_so", so, 0);
    chk("reset_busy", busy, 0);
    chk("reset_txdone", tx_done, 0);
    chk("reset_ready", data_ready, 0);
    release_reset();
    chk("ready_after_release", data_ready, 1);
    chk("busy_after_release", busy, 1);
    send(40'hA5_5A0F_F0C3, 1'b0);
    drain_and_idle("first");

    // back-to-back words: exactly GAP low cycles between frames
    send(40'h00_0000_0001, 1'b0);
    send(40'h80_0000_0000, 1'b0);
    #1;
    chk("b2b_ready_held", data_ready, 0);
    drain_and_idle("b2b");

    // random words with random spacing, including back-to-back
    for (int i = 0; i < 10; i++) begin
      send(rnd40(), 1'b0);
      n = $urandom_range(0, 3);
      if (n != 0) repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    drain_and_idle("random");

    // backpressure: third word waits with data churning until the hold frees
    send(rnd40(), 1'b0);
    send(rnd40(), 1'b0);
    send(rnd40(), 1'b1);
    drain_and_idle("backpressure");

    // reset at bit 20 with a second word held: both are discarded
    send(rnd40(), 1'b0);
    send(rnd40(), 1'b0);
    n = 0;
    while (!(in_frame && (cyc - fst) == 20) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!(in_frame && (cyc - fst) == 20)) fail("midframe_wait_timeout");
    #2 rst_n = 1'b0;
    q.delete();
    prev_st = -1000;
    #1;
    chk("midreset_so", so, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", data_ready, 0);
    release_reset();
    send(rnd40(), 1'b0);
    drain_and_idle("after_reset");

    // all-zero word
    send('0, 1'b0);
    drain_and_idle("zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
